// File: rtl/serial_adder_w.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop walks two
// WIDTH-bit operands LSB-first under a start/done handshake, with optional accumulate.
module serial_adder_w #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             bit_sum;
  logic             carry_next;
  logic [WIDTH-1:0] work_next;

  // Full-adder slice on the operand LSBs; the new bit enters the working sum at the MSB.
  always_comb begin
    bit_sum    = opa[0] ^ opb[0] ^ carry;
    carry_next = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    work_next  = (work >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
  end

  // Control FSM with datapath registers; accepting in DONE gives back-to-back operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + ~borrow, so the borrow-in is inverted into the carry.
            opa   <= acc ? sum : a;
            opb   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          work  <= work_next;
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= work_next;
            cout  <= carry_next;
            ovf   <= carry ^ carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_w.sv
// Directed bench for serial_adder_w: an 8-bit instance for the arithmetic and
// handshake cases, and a 1-bit instance swept over the full-adder truth table.
module tb_serial_adder_w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, sub8, acc8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start1, sub1, acc1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;
  int ndone8 = 0;

  serial_adder_w #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .acc(acc8),
    .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_w #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .acc(acc1),
    .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  always @(negedge clk) if (done8 === 1'b1) ndone8++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present an operation at a negedge; returns at the negedge after the accepting edge.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic s, input logic ac);
    a8 = a; b8 = b; cin8 = c; sub8 = s; acc8 = ac; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("busy_e0", {31'd0, busy8}, 32'd1);
  endtask

  task automatic wait8(input string tag, input int exp_lat);
    int cyc = 0;
    int nb  = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) nb++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_busycyc"}, nb, exp_lat);
    check({tag, "_busy_at_done"}, {31'd0, busy8}, 32'd0);
  endtask

  task automatic res8(input string tag, input logic [7:0] s, input logic c, input logic o);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, s});
    check({tag, "_cout"}, {31'd0, cout8}, {31'd0, c});
    check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, o});
  endtask

  logic [15:0] sum_tab  = 16'h9696;
  logic [15:0] cout_tab = 16'h71E8;
  int n0;

  initial begin
    rst = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; acc8 = 1'b0; cin8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    start1 = 1'b0; sub1 = 1'b0; acc1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    res8("rst", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    go8(8'd200, 8'd100, 1'b0, 1'b0, 1'b0);
    wait8("add1", 8);
    res8("add1", 8'd44, 1'b1, 1'b0);
    @(negedge clk);
    check("add1_done_low", {31'd0, done8}, 32'd0);

    go8(8'd100, 8'd50, 1'b0, 1'b0, 1'b0);
    wait8("add2", 8);
    res8("add2", 8'd150, 1'b0, 1'b1);
    @(negedge clk);

    go8(8'd5, 8'd7, 1'b0, 1'b1, 1'b0);
    wait8("sub", 8);
    res8("sub", 8'd254, 1'b0, 1'b0);
    @(negedge clk);

    // Accumulate chain: second start issued in the DONE cycle, port a ignored.
    go8(8'd3, 8'd0, 1'b0, 1'b0, 1'b0);
    wait8("acc0", 8);
    res8("acc0", 8'd3, 1'b0, 1'b0);
    go8(8'd99, 8'd4, 1'b0, 1'b0, 1'b1);
    check("acc_done_low", {31'd0, done8}, 32'd0);
    wait8("acc1", 8);
    res8("acc1", 8'd7, 1'b0, 1'b0);
    @(negedge clk);

    // start during RUN must be ignored
    n0 = ndone8;
    go8(8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd77; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8("midrun", 6);
    res8("midrun", 8'd30, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("midrun_idle", {31'd0, busy8}, 32'd0);
    check("midrun_ndone", ndone8 - n0, 32'd1);

    // Reset in the middle of a run
    go8(8'd50, 8'd60, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstrun_busy", {31'd0, busy8}, 32'd0);
    check("rstrun_done", {31'd0, done8}, 32'd0);
    res8("rstrun", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n0 = ndone8;
    repeat (12) @(negedge clk);
    check("rstrun_nodone", ndone8 - n0, 32'd0);
    check("rstrun_sum_hold", {24'd0, sum8}, 32'd0);

    // WIDTH=1 truth table, index {sub,a,b,cin}
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = i[3:0];
      sub1 = v[3]; a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check($sformatf("w1_busy_%0d", i), {31'd0, busy1}, 32'd1);
      @(negedge clk);
      check($sformatf("w1_done_%0d", i), {31'd0, done1}, 32'd1);
      check($sformatf("w1_sum_%0d", i), {31'd0, sum1}, {31'd0, sum_tab[i]});
      check($sformatf("w1_cout_%0d", i), {31'd0, cout1}, {31'd0, cout_tab[i]});
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_w.md
# serial_adder_w

Parametrised bit-serial adder/subtractor with optional accumulate mode. It is the multi-bit successor to the team's single-bit full-adder block. One full-adder slice and a carry flip-flop process two WIDTH-bit operands LSB-first, one bit per clock, under a start/done handshake. It sits behind the tile's dedicated inputs as a small arithmetic unit and trades latency for area.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only when not busy.
- sub  in  1  0 = A + B + cin; 1 = A − B − cin (cin acts as borrow-in).
- acc  in  1  1 = use the current result register as operand A instead of port a.
- a  in  WIDTH  operand A, captured on the accepting edge.
- b  in  WIDTH  operand B, captured on the accepting edge.
- cin  in  1  carry-in / borrow-in, captured on the accepting edge.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when the results update.
- sum  out  WIDTH  result register.
- cout  out  1  raw carry out of the MSB; for sub, cout = 0 means a borrow occurred.
- ovf  out  1  two's-complement overflow of the last operation.

## Operation
- States: IDLE, RUN, DONE. A bit counter (width ceil(log2(WIDTH+1))) counts processed bits.
- Accept: start=1 in IDLE or DONE.
  - Load opA = acc ? sum : a.
  - Load opB = sub ? ~b : b.
  - Load carry = sub ? ~cin : cin.
  - Clear the counter; go to RUN.
- start in RUN is ignored; it is neither queued nor able to abort the operation.
- RUN, each edge:
  - s = opA[0]^opB[0]^carry; carry' = majority(opA[0], opB[0], carry).
  - Shift opA and opB right by one; shift s into the MSB of the working sum register.
  - Increment the counter.
- Final bit (counter = WIDTH−1):
  - Latch the working sum into sum.
  - cout ← carry'.
  - ovf ← carry ^ carry', i.e. carry into the MSB XOR carry out of the MSB.
  - Go to DONE.
- DONE lasts one cycle, then returns to IDLE unless start is accepted in that cycle.
- sum, cout and ovf hold their values between operations. They change only on the final-bit edge and on reset; the working register is internal.
- Arithmetic is modulo 2^WIDTH. sub computes A + ~B + ~bin.
- acc with sub computes sum − b − cin, which supports chained accumulation.
- WIDTH=1 degenerates to a registered full adder: RUN lasts 1 cycle.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; busy = 0; done = 0; sum = 0; cout = 0; ovf = 0.
  - Working registers and counter = 0.
- Reset mid-RUN abandons the operation: no done pulse, and the results are zero rather than partial.
- Accepting edge E0: busy = 1 from E0 until edge EW.
- Bits are processed on edges E1..EW, so RUN lasts exactly WIDTH cycles.
- After EW:
  - busy = 0, done = 1.
  - sum, cout and ovf hold the new values.
- After EW+1: done = 0.
- Latency from the accepting edge to valid results and done is WIDTH cycles.
- Back-to-back operation: start held high in the DONE cycle is accepted at EW+1, and busy rises again without any IDLE cycle. Throughput is one operation per WIDTH+1 cycles.
- acc in the DONE-cycle accept uses the just-latched sum.

## Test plan
- WIDTH=8, a=200, b=100, cin=0, sub=0:
  - busy high for 8 cycles, then done pulses once.
  - sum=44, cout=1, ovf=0.
- WIDTH=8, a=100, b=50, add → sum=150, cout=0, ovf=1.
- WIDTH=8, a=5, b=7, sub=1, cin=0 → sum=254, cout=0 (borrow), ovf=0.
- WIDTH=8, accumulate chain:
  - a=3, b=0 → sum=3.
  - Then start held in the DONE cycle with acc=1, b=4 → sum=7 after 8 more cycles, with no IDLE gap.
- WIDTH=8, start pulsed again mid-RUN with different a/b:
  - The operation is unaffected, with exactly one done pulse.
  - Then assert rst in the middle of a new RUN: all outputs are 0 immediately and no done pulse follows.
- WIDTH=1, exhaustive over a, b, cin and sub:
  - done follows the accept by 1 cycle.
  - sum/cout match the full-adder truth table; e.g. add 1+1+1 → sum=1, cout=1.
